// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one word-aligned load or store at a time, inserts
// WAIT_CYCLES wait states, then returns a registered one-cycle ready with data or error.
module dmem_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        mr_i,
    input  logic        mw_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ready_o,
    output logic        err_o,
    output logic        busy_o
);
    localparam int unsigned Depth = 2 ** ADDR_W;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   word_q, word_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                write_q, write_d;
    logic                illegal_q, illegal_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;

    logic [31:0]         mem [Depth];

    logic [ADDR_W-1:0]   in_word;
    logic                in_illegal;
    logic                acc_en;
    logic [ADDR_W-1:0]   acc_word;
    logic [31:0]         acc_wdata;
    logic                acc_write;
    logic                acc_illegal;
    logic                mem_we;

    assign in_word    = addr_i[ADDR_W+1:2];
    assign in_illegal = (mr_i & mw_i) | (addr_i[1:0] != 2'b00) |
                        ((addr_i >> (ADDR_W + 2)) != '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        illegal_d   = illegal_q;
        rdata_d     = rdata_q;
        ready_d     = 1'b0;
        err_d       = err_q;
        busy_d      = busy_q;
        acc_en      = 1'b0;
        acc_word    = word_q;
        acc_wdata   = wdata_q;
        acc_write   = write_q;
        acc_illegal = illegal_q;

        case (state_q)
            StIdle: begin
                if (mr_i | mw_i) begin
                    word_d    = in_word;
                    wdata_d   = wdata_i;
                    write_d   = mw_i;
                    illegal_d = in_illegal;
                    busy_d    = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        // Zero wait states: the access happens on the acceptance edge itself.
                        acc_en      = 1'b1;
                        acc_word    = in_word;
                        acc_wdata   = wdata_i;
                        acc_write   = mw_i;
                        acc_illegal = in_illegal;
                        state_d     = StResp;
                    end else begin
                        cnt_d   = 4'(WAIT_CYCLES);
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    acc_en  = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                busy_d  = 1'b0;
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (acc_en) begin
            ready_d = 1'b1;
            if (acc_illegal) begin
                rdata_d = '0;
                err_d   = 1'b1;
            end else begin
                err_d = 1'b0;
                if (!acc_write) begin
                    rdata_d = mem[acc_word];
                end
            end
        end
    end

    assign mem_we = acc_en & acc_write & ~acc_illegal;

    // RAM has no reset; reset only suppresses an in-flight write.
    always_ff @(posedge clk_i) begin
        if (!reset_i && mem_we) begin
            mem[acc_word] <= acc_wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            word_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            illegal_q <= 1'b0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            illegal_q <= illegal_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign rdata_o = rdata_q;
    assign ready_o = ready_q;
    assign err_o   = err_q;
    assign busy_o  = busy_q;

endmodule
